// File: rtl/axi_read_arbiter.sv
// Two-requester AXI4 read-channel arbiter (IFU = requester 0, LSU = requester 1).
// One whole read transaction (AR handshake through last R beat) owns the
// downstream port at a time. A sticky flag records burst-length and ID errors.
module axi_read_arbiter #(
    parameter int         ROUND_ROBIN = 1,
    parameter logic [3:0] ID0         = 4'h0,
    parameter logic [3:0] ID1         = 4'h1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        m0_arvalid,
    output logic        m0_arready,
    input  logic [31:0] m0_araddr,
    input  logic [7:0]  m0_arlen,
    input  logic [2:0]  m0_arsize,
    output logic        m0_rvalid,
    input  logic        m0_rready,
    output logic [31:0] m0_rdata,
    output logic [1:0]  m0_rresp,
    output logic        m0_rlast,
    input  logic        m1_arvalid,
    output logic        m1_arready,
    input  logic [31:0] m1_araddr,
    input  logic [7:0]  m1_arlen,
    input  logic [2:0]  m1_arsize,
    output logic        m1_rvalid,
    input  logic        m1_rready,
    output logic [31:0] m1_rdata,
    output logic [1:0]  m1_rresp,
    output logic        m1_rlast,
    output logic        s_arvalid,
    input  logic        s_arready,
    output logic [31:0] s_araddr,
    output logic [7:0]  s_arlen,
    output logic [2:0]  s_arsize,
    output logic [1:0]  s_arburst,
    output logic [3:0]  s_arid,
    input  logic        s_rvalid,
    output logic        s_rready,
    input  logic [31:0] s_rdata,
    input  logic [1:0]  s_rresp,
    input  logic        s_rlast,
    input  logic [3:0]  s_rid,
    output logic        err_burst
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_grant_q, last_grant_d;
    logic        err_burst_q, err_burst_d;
    logic [7:0]  beat_cnt_q, beat_cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  len_q, len_d;
    logic [2:0]  size_q, size_d;

    logic        any_req;
    logic        winner;
    logic        grant_en;
    logic        in_data;
    logic        owner_rready;
    logic [3:0]  owner_id;
    logic        r_hs;

    // Winner selection: on a tie, round-robin favours the requester not granted last.
    always_comb begin
        any_req = m0_arvalid | m1_arvalid;
        winner  = 1'b0;
        if (m0_arvalid && m1_arvalid) begin
            winner = (ROUND_ROBIN != 0) ? ~last_grant_q : 1'b1;
        end else begin
            winner = m1_arvalid;
        end
    end

    // Handshake and pass-through outputs; R path is combinational to the owner.
    always_comb begin
        grant_en     = (state_q == ST_IDLE) && any_req;
        in_data      = (state_q == ST_DATA);
        owner_rready = owner_q ? m1_rready : m0_rready;
        owner_id     = owner_q ? ID1 : ID0;

        m0_arready   = grant_en && !winner;
        m1_arready   = grant_en && winner;

        s_rready     = in_data && owner_rready;
        m0_rvalid    = in_data && !owner_q && s_rvalid;
        m1_rvalid    = in_data && owner_q && s_rvalid;
        m0_rdata     = s_rdata;
        m1_rdata     = s_rdata;
        m0_rresp     = s_rresp;
        m1_rresp     = s_rresp;
        m0_rlast     = s_rlast;
        m1_rlast     = s_rlast;

        s_arvalid    = (state_q == ST_ADDR);
        s_araddr     = addr_q;
        s_arlen      = len_q;
        s_arsize     = size_q;
        s_arburst    = 2'b01;
        s_arid       = owner_id;

        r_hs         = s_rvalid && s_rready;
        err_burst    = err_burst_q;
    end

    // Next-state logic: grant in IDLE, hold AR in ADDR, count and check beats in DATA.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        err_burst_d  = err_burst_q;
        beat_cnt_d   = beat_cnt_q;
        addr_d       = addr_q;
        len_d        = len_q;
        size_d       = size_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    addr_d       = winner ? m1_araddr : m0_araddr;
                    len_d        = winner ? m1_arlen  : m0_arlen;
                    size_d       = winner ? m1_arsize : m0_arsize;
                    owner_d      = winner;
                    last_grant_d = winner;
                    beat_cnt_d   = '0;
                    state_d      = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (s_arready) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_hs) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if ((s_rlast && (beat_cnt_q != len_q)) ||
                        (!s_rlast && (beat_cnt_q == len_q)) ||
                        (s_rid != owner_id)) begin
                        err_burst_d = 1'b1;
                    end
                    if (s_rlast) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            err_burst_q  <= 1'b0;
            beat_cnt_q   <= '0;
            addr_q       <= '0;
            len_q        <= '0;
            size_q       <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            err_burst_q  <= err_burst_d;
            beat_cnt_q   <= beat_cnt_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            size_q       <= size_d;
        end
    end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Bench for axi_read_arbiter: instance 0 is round-robin, instance 1 is fixed
// priority. Returned beats are checked against a scoreboard of expected beats.
module tb_axi_read_arbiter;

    typedef struct {
        int          dut;
        int          who;
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic        m0_arvalid [2];
    logic        m0_arready [2];
    logic [31:0] m0_araddr  [2];
    logic [7:0]  m0_arlen   [2];
    logic [2:0]  m0_arsize  [2];
    logic        m0_rvalid  [2];
    logic        m0_rready  [2];
    logic [31:0] m0_rdata   [2];
    logic [1:0]  m0_rresp   [2];
    logic        m0_rlast   [2];
    logic        m1_arvalid [2];
    logic        m1_arready [2];
    logic [31:0] m1_araddr  [2];
    logic [7:0]  m1_arlen   [2];
    logic [2:0]  m1_arsize  [2];
    logic        m1_rvalid  [2];
    logic        m1_rready  [2];
    logic [31:0] m1_rdata   [2];
    logic [1:0]  m1_rresp   [2];
    logic        m1_rlast   [2];
    logic        s_arvalid  [2];
    logic        s_arready  [2];
    logic [31:0] s_araddr   [2];
    logic [7:0]  s_arlen    [2];
    logic [2:0]  s_arsize   [2];
    logic [1:0]  s_arburst  [2];
    logic [3:0]  s_arid     [2];
    logic        s_rvalid   [2];
    logic        s_rready   [2];
    logic [31:0] s_rdata    [2];
    logic [1:0]  s_rresp    [2];
    logic        s_rlast    [2];
    logic [3:0]  s_rid      [2];
    logic        err_burst  [2];

    int    checks   = 0;
    int    failures = 0;
    beat_t sb[$];

    for (genvar k = 0; k < 2; k++) begin : g_dut
        axi_read_arbiter #(
            .ROUND_ROBIN((k == 0) ? 1 : 0),
            .ID0        (4'h0),
            .ID1        (4'h1)
        ) u_dut (
            .clock     (clock),
            .reset     (reset),
            .m0_arvalid(m0_arvalid[k]),
            .m0_arready(m0_arready[k]),
            .m0_araddr (m0_araddr[k]),
            .m0_arlen  (m0_arlen[k]),
            .m0_arsize (m0_arsize[k]),
            .m0_rvalid (m0_rvalid[k]),
            .m0_rready (m0_rready[k]),
            .m0_rdata  (m0_rdata[k]),
            .m0_rresp  (m0_rresp[k]),
            .m0_rlast  (m0_rlast[k]),
            .m1_arvalid(m1_arvalid[k]),
            .m1_arready(m1_arready[k]),
            .m1_araddr (m1_araddr[k]),
            .m1_arlen  (m1_arlen[k]),
            .m1_arsize (m1_arsize[k]),
            .m1_rvalid (m1_rvalid[k]),
            .m1_rready (m1_rready[k]),
            .m1_rdata  (m1_rdata[k]),
            .m1_rresp  (m1_rresp[k]),
            .m1_rlast  (m1_rlast[k]),
            .s_arvalid (s_arvalid[k]),
            .s_arready (s_arready[k]),
            .s_araddr  (s_araddr[k]),
            .s_arlen   (s_arlen[k]),
            .s_arsize  (s_arsize[k]),
            .s_arburst (s_arburst[k]),
            .s_arid    (s_arid[k]),
            .s_rvalid  (s_rvalid[k]),
            .s_rready  (s_rready[k]),
            .s_rdata   (s_rdata[k]),
            .s_rresp   (s_rresp[k]),
            .s_rlast   (s_rlast[k]),
            .s_rid     (s_rid[k]),
            .err_burst (err_burst[k])
        );
    end

    // Scoreboard monitor: every requester-side R handshake must match the oldest expected beat.
    always @(negedge clock) begin : mon
        beat_t       e;
        logic        v;
        logic        r;
        logic        l;
        logic [31:0] d;
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < 2; i++) begin
                    v = (i == 0) ? m0_rvalid[k] : m1_rvalid[k];
                    r = (i == 0) ? m0_rready[k] : m1_rready[k];
                    d = (i == 0) ? m0_rdata[k]  : m1_rdata[k];
                    l = (i == 0) ? m0_rlast[k]  : m1_rlast[k];
                    if (v && r) begin
                        checks++;
                        if (sb.size() == 0) begin
                            failures++;
                            $display("FAIL unexpected_beat dut=%0d req=%0d got data=%h last=%0b want none", k, i, d, l);
                        end else begin
                            e = sb.pop_front();
                            if (e.dut != k || e.who != i || e.data !== d || e.last !== l) begin
                                failures++;
                                $display("FAIL r_beat got dut=%0d req=%0d data=%h last=%0b want dut=%0d req=%0d data=%h last=%0b",
                                         k, i, d, l, e.dut, e.who, e.data, e.last);
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_all();
        for (int k = 0; k < 2; k++) begin
            m0_arvalid[k] = 1'b0; m0_araddr[k] = '0; m0_arlen[k] = '0; m0_arsize[k] = '0; m0_rready[k] = 1'b1;
            m1_arvalid[k] = 1'b0; m1_araddr[k] = '0; m1_arlen[k] = '0; m1_arsize[k] = '0; m1_rready[k] = 1'b1;
            s_arready[k]  = 1'b0; s_rvalid[k]  = 1'b0; s_rdata[k]  = '0; s_rresp[k]  = '0;
            s_rlast[k]    = 1'b0; s_rid[k]     = '0;
        end
    endtask

    task automatic do_reset();
        idle_all();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic addr_accept(input int k);
        s_arready[k] = 1'b1;
        step();
        s_arready[k] = 1'b0;
    endtask

    // Downstream responder: presents n beats, holding each until s_rready accepts it.
    task automatic send_beats(input int k, input int who, input int n, input logic [31:0] base,
                              input logic [3:0] rid, input int last_idx);
        beat_t e;
        int    t;
        for (int b = 0; b < n; b++) begin
            s_rvalid[k] = 1'b1;
            s_rdata[k]  = base + 32'(b);
            s_rlast[k]  = (b == last_idx);
            s_rid[k]    = rid;
            s_rresp[k]  = 2'b00;
            e.dut = k; e.who = who; e.data = base + 32'(b); e.last = (b == last_idx);
            sb.push_back(e);
            t = 0;
            @(negedge clock);
            while (!s_rready[k] && t < 50) begin
                step();
                @(negedge clock);
                t++;
            end
            if (!s_rready[k]) begin
                checks++; failures++;
                $display("FAIL beat_timeout dut=%0d beat=%0d got s_rready=0 want 1", k, b);
                void'(sb.pop_back());
                s_rvalid[k] = 1'b0;
                s_rlast[k]  = 1'b0;
                return;
            end
            step();
        end
        s_rvalid[k] = 1'b0;
        s_rlast[k]  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clock);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({s_arvalid[k], s_rready[k], m0_arready[k], m1_arready[k], m0_rvalid[k], m1_rvalid[k], err_burst[k]} !== 7'b0) begin
                failures++;
                $display("FAIL reset_ctrl dut=%0d got %b want 0000000", k,
                         {s_arvalid[k], s_rready[k], m0_arready[k], m1_arready[k], m0_rvalid[k], m1_rvalid[k], err_burst[k]});
            end
            checks++;
            if (s_araddr[k] !== 32'h0 || s_arlen[k] !== 8'h0 || s_arsize[k] !== 3'h0) begin
                failures++;
                $display("FAIL reset_fields dut=%0d got addr=%h len=%h size=%h want 0", k, s_araddr[k], s_arlen[k], s_arsize[k]);
            end
        end
        step();
    endtask

    task automatic test_single();
        do_reset();
        m0_arvalid[0] = 1'b1; m0_araddr[0] = 32'h8000_0000; m0_arlen[0] = 8'd0; m0_arsize[0] = 3'd2;
        @(negedge clock);
        checks++;
        if ({m1_arready[0], m0_arready[0]} !== 2'b01) begin
            failures++;
            $display("FAIL single_grant got m1/m0_arready=%b want 01", {m1_arready[0], m0_arready[0]});
        end
        step();
        m0_arvalid[0] = 1'b0;
        @(negedge clock);
        checks++;
        if (s_arvalid[0] !== 1'b1 || s_arid[0] !== 4'h0 || s_arburst[0] !== 2'b01) begin
            failures++;
            $display("FAIL single_ar got valid=%b id=%h burst=%b want 1 0 01", s_arvalid[0], s_arid[0], s_arburst[0]);
        end
        checks++;
        if (s_araddr[0] !== 32'h8000_0000 || s_arlen[0] !== 8'd0 || s_arsize[0] !== 3'd2) begin
            failures++;
            $display("FAIL single_fields got addr=%h len=%h size=%h want 80000000 00 2", s_araddr[0], s_arlen[0], s_arsize[0]);
        end
        addr_accept(0);
        send_beats(0, 0, 1, 32'hDEAD_BEEF, 4'h0, 0);
        @(negedge clock);
        checks++;
        if ({s_rready[0], s_arvalid[0], err_burst[0]} !== 3'b000) begin
            failures++;
            $display("FAIL single_done got rready/arvalid/err=%b want 000", {s_rready[0], s_arvalid[0], err_burst[0]});
        end
        step();
    endtask

    task automatic test_tie(input int k);
        int          w;
        logic [3:0]  eid;
        logic [31:0] eaddr;
        do_reset();
        m0_araddr[k] = 32'h0000_1000; m0_arlen[k] = 8'd0;
        m1_araddr[k] = 32'h0000_2000; m1_arlen[k] = 8'd0;
        m0_arvalid[k] = 1'b1; m1_arvalid[k] = 1'b1;
        for (int t = 0; t < 4; t++) begin
            w     = (k == 0) ? (t % 2) : 1;
            eid   = (w == 1) ? 4'h1 : 4'h0;
            eaddr = (w == 1) ? 32'h0000_2000 : 32'h0000_1000;
            @(negedge clock);
            checks++;
            if ({m1_arready[k], m0_arready[k]} !== ((w == 1) ? 2'b10 : 2'b01)) begin
                failures++;
                $display("FAIL tie_grant dut=%0d txn=%0d got m1/m0_arready=%b want req%0d", k, t, {m1_arready[k], m0_arready[k]}, w);
            end
            step();
            @(negedge clock);
            checks++;
            if ({m1_arready[k], m0_arready[k]} !== 2'b00 || s_arid[k] !== eid || s_araddr[k] !== eaddr) begin
                failures++;
                $display("FAIL tie_addr dut=%0d txn=%0d got arready=%b id=%h addr=%h want 00 %h %h",
                         k, t, {m1_arready[k], m0_arready[k]}, s_arid[k], s_araddr[k], eid, eaddr);
            end
            addr_accept(k);
            send_beats(k, w, 1, 32'h5000_0000 + 32'(t), eid, 0);
        end
        m0_arvalid[k] = 1'b0; m1_arvalid[k] = 1'b0;
        step();
    endtask

    task automatic test_burst();
        do_reset();
        m1_arvalid[0] = 1'b1; m1_araddr[0] = 32'h0000_3000; m1_arlen[0] = 8'd3; m1_arsize[0] = 3'd2;
        @(negedge clock);
        checks++;
        if (m1_arready[0] !== 1'b1) begin
            failures++;
            $display("FAIL burst_grant got m1_arready=%b want 1", m1_arready[0]);
        end
        step();
        m1_arvalid[0] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            checks++;
            if (s_arvalid[0] !== 1'b1 || s_araddr[0] !== 32'h0000_3000 || s_arlen[0] !== 8'd3 || s_arid[0] !== 4'h1) begin
                failures++;
                $display("FAIL burst_ar_hold cyc=%0d got valid=%b addr=%h len=%h id=%h want 1 00003000 03 1",
                         c, s_arvalid[0], s_araddr[0], s_arlen[0], s_arid[0]);
            end
            step();
        end
        addr_accept(0);
        fork
            send_beats(0, 1, 4, 32'hA000_0000, 4'h1, 3);
            begin
                for (int c = 0; c < 10; c++) begin
                    m1_rready[0] = ~m1_rready[0];
                    step();
                end
                m1_rready[0] = 1'b1;
            end
        join
        @(negedge clock);
        checks++;
        if ({err_burst[0], s_rready[0], s_arvalid[0]} !== 3'b000) begin
            failures++;
            $display("FAIL burst_done got err/rready/arvalid=%b want 000", {err_burst[0], s_rready[0], s_arvalid[0]});
        end
        step();
    endtask

    task automatic test_len_err();
        do_reset();
        m0_arvalid[0] = 1'b1; m0_araddr[0] = 32'h0000_4000; m0_arlen[0] = 8'd1;
        @(negedge clock);
        checks++;
        if (m0_arready[0] !== 1'b1) begin
            failures++;
            $display("FAIL lenerr_grant got m0_arready=%b want 1", m0_arready[0]);
        end
        step();
        m0_arvalid[0] = 1'b0;
        addr_accept(0);
        send_beats(0, 0, 1, 32'hB000_0000, 4'h0, 0);
        @(negedge clock);
        checks++;
        if (err_burst[0] !== 1'b1 || s_rready[0] !== 1'b0) begin
            failures++;
            $display("FAIL lenerr_flag got err=%b rready=%b want 1 0", err_burst[0], s_rready[0]);
        end
        step();
        m1_arvalid[0] = 1'b1; m1_araddr[0] = 32'h0000_4100; m1_arlen[0] = 8'd0;
        @(negedge clock);
        checks++;
        if (m1_arready[0] !== 1'b1) begin
            failures++;
            $display("FAIL lenerr_next_grant got m1_arready=%b want 1", m1_arready[0]);
        end
        step();
        m1_arvalid[0] = 1'b0;
        addr_accept(0);
        send_beats(0, 1, 1, 32'hC000_0000, 4'h1, 0);
        @(negedge clock);
        checks++;
        if (err_burst[0] !== 1'b1 || s_rready[0] !== 1'b0) begin
            failures++;
            $display("FAIL lenerr_sticky got err=%b rready=%b want 1 0", err_burst[0], s_rready[0]);
        end
        step();
    endtask

    task automatic test_id_err();
        do_reset();
        m0_arvalid[1] = 1'b1; m0_araddr[1] = 32'h0000_5000; m0_arlen[1] = 8'd0;
        @(negedge clock);
        checks++;
        if ({m1_arready[1], m0_arready[1]} !== 2'b01) begin
            failures++;
            $display("FAIL iderr_grant got m1/m0_arready=%b want 01", {m1_arready[1], m0_arready[1]});
        end
        step();
        m0_arvalid[1] = 1'b0;
        addr_accept(1);
        send_beats(1, 0, 1, 32'hD000_0000, 4'h1, 0);
        @(negedge clock);
        checks++;
        if (err_burst[1] !== 1'b1) begin
            failures++;
            $display("FAIL iderr_flag got err=%b want 1", err_burst[1]);
        end
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        m0_arvalid[0] = 1'b1; m0_araddr[0] = 32'h0000_6000; m0_arlen[0] = 8'd3;
        step();
        m0_arvalid[0] = 1'b0;
        addr_accept(0);
        send_beats(0, 0, 2, 32'hE000_0000, 4'h0, 3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        s_rvalid[0] = 1'b1; s_rdata[0] = 32'h0000_0BAD; s_rlast[0] = 1'b0;
        @(negedge clock);
        checks++;
        if ({s_rready[0], m0_rvalid[0], m1_rvalid[0], s_arvalid[0], m0_arready[0], m1_arready[0], err_burst[0]} !== 7'b0) begin
            failures++;
            $display("FAIL midreset_ctrl got %b want 0000000",
                     {s_rready[0], m0_rvalid[0], m1_rvalid[0], s_arvalid[0], m0_arready[0], m1_arready[0], err_burst[0]});
        end
        checks++;
        if (s_araddr[0] !== 32'h0 || s_arlen[0] !== 8'h0) begin
            failures++;
            $display("FAIL midreset_fields got addr=%h len=%h want 0 0", s_araddr[0], s_arlen[0]);
        end
        s_rvalid[0] = 1'b0;
        m0_arvalid[0] = 1'b1; m1_arvalid[0] = 1'b1;
        #1;
        checks++;
        if ({m1_arready[0], m0_arready[0]} !== 2'b01) begin
            failures++;
            $display("FAIL midreset_rr got m1/m0_arready=%b want 01", {m1_arready[0], m0_arready[0]});
        end
        m0_arvalid[0] = 1'b0; m1_arvalid[0] = 1'b0;
        step();
    endtask

    initial begin
        idle_all();
        test_reset();
        test_single();
        test_tie(0);
        test_tie(1);
        test_burst();
        test_len_err();
        test_id_err();
        test_reset_mid();
        do_reset();
        @(negedge clock);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
- Shares the single AXI4 read channel to the memory/peripheral subsystem between two requesters: requester 0 (IFU instruction fetch) and requester 1 (LSU load).
- Sits between the core's fetch and load units and the `io_master_ar*`/`r*` port.
- Grants one whole read transaction (AR handshake through the last R beat) at a time.
- Checks burst length consistency and flags protocol errors.

Parameters:
- ROUND_ROBIN, 1, 1 = round-robin grant between requesters; 0 = fixed priority with requester 1 (LSU) winning.
- ID0, 4'h0, value driven on `s_arid` for requester 0 transactions.
- ID1, 4'h1, value driven on `s_arid` for requester 1 transactions.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m{i}_arvalid  in  1  requester i read request valid (i = 0, 1; 0 = IFU, 1 = LSU)
- m{i}_arready  out  1  requester i request accepted
- m{i}_araddr  in  32  requester i byte address
- m{i}_arlen  in  8  requester i beats minus one
- m{i}_arsize  in  3  requester i bytes per beat (log2)
- m{i}_rvalid  out  1  read data valid to requester i
- m{i}_rready  in  1  requester i ready for data
- m{i}_rdata  out  32  read data to requester i
- m{i}_rresp  out  2  response to requester i
- m{i}_rlast  out  1  last beat to requester i
- s_arvalid  out  1  downstream request valid
- s_arready  in  1  downstream request accepted
- s_araddr  out  32  latched address
- s_arlen  out  8  latched length
- s_arsize  out  3  latched size
- s_arburst  out  2  constant 2'b01 (INCR)
- s_arid  out  4  ID0 or ID1 of the owner
- s_rvalid  in  1  downstream data valid
- s_rready  out  1  downstream data ready
- s_rdata  in  32  downstream data
- s_rresp  in  2  downstream response
- s_rlast  in  1  downstream last beat
- s_rid  in  4  downstream ID (checked only)
- err_burst  out  1  sticky protocol error flag

Behaviour:
- Reset: state IDLE, owner = 0, last_grant = 1 (so requester 0 wins first under round-robin), `err_burst` = 0, beat counter = 0. All valid/ready outputs are 0; `s_araddr`/`s_arlen`/`s_arsize` = 0.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If any `m{i}_arvalid` is high, select the winner. Under round-robin, the requester not equal to last_grant wins a tie; under fixed priority, requester 1 wins a tie.
  - `m{winner}_arready` = 1 combinationally in this same cycle; the loser's `arready` = 0.
  - On the clock edge: latch addr/len/size, owner = winner, last_grant = winner, beat counter = 0, go to ADDR.
  - No request: stay in IDLE.
- ADDR:
  - `s_arvalid` = 1 with the latched fields held stable.
  - On `s_arvalid & s_arready`, go to DATA. Remain in ADDR indefinitely while `s_arready` = 0.
  - Both `m{i}_arready` = 0.
- DATA:
  - `m{owner}_rvalid` = `s_rvalid`; rdata/rresp/rlast pass through combinationally. `s_rready` = `m{owner}_rready`. The non-owner's `rvalid` = 0.
  - Each R handshake increments the beat counter (8 bit).
  - A handshake with `s_rlast` = 1 returns the FSM to IDLE. The next grant occurs in IDLE no earlier than the following cycle, giving a minimum 1-cycle bubble between transactions.
- Outside DATA, `s_rready` = 0: stray downstream beats are stalled, never dropped.
- Latency: request accept in cycle N; `s_arvalid` asserted in N+1; first data is forwarded in the same cycle it arrives (zero-cycle R path).
- `err_burst` is set (sticky until reset) on any of:
  - an `s_rlast` handshake with beat counter != latched len;
  - a handshake with `s_rlast` = 0 when beat counter == latched len;
  - an R handshake with `s_rid` != owner's ID.

  The transaction still completes on `s_rlast`.
- Simultaneous events:
  - The AR handshake and a new `m{i}_arvalid` in the same cycle: the new request waits; its `arready` stays 0.
  - The loser keeps `arvalid` asserted and is granted at the next IDLE. Round-robin guarantees it wins if the winner re-requests immediately.
- Reset mid-transaction returns the FSM to IDLE immediately; remaining downstream beats are not consumed (the system resets the downstream together).

Test Plan:
- Single request: m0 ar addr=0x80000000 len=0 → m0_arready=1 same cycle; s_arvalid next cycle with s_arid=ID0, s_arburst=01; one beat 0xDEADBEEF returned to m0 with rlast; m1_rvalid stays 0.
- Tie, ROUND_ROBIN=1: both request every cycle → grants alternate m0, m1, m0, m1 over 4 transactions. With ROUND_ROBIN=0 → m1 is always granted while it requests.
- Burst: m1 len=3, s_arready delayed 5 cycles, m1_rready toggling → 4 beats delivered in order, beat counter reaches 3, FSM returns to IDLE, err_burst=0.
- Length error: len=1, downstream asserts rlast on beat 0 → err_burst=1 stays set; FSM returns to IDLE; a subsequent clean transaction succeeds.
- ID error: owner m0, downstream returns s_rid=4'h1 → err_burst=1.
- Reset asserted in DATA after 2 of 4 beats → next cycle state IDLE, all valid/ready outputs 0, err_burst=0, last_grant=1.
